bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly downstream of the 6-bit BCD-to-binary converter and of the 6-bit counter output. It turns their binary results back into packed BCD digits for display and round-trip checking.
- Uses a valid/ready handshake on both sides. It processes one conversion at a time, one bit per clock.

Parameters:
- WIDTH, 6, binary input width in bits (legal range 2..16).
- DIGITS, 2, number of 4-bit BCD output digits (legal range 1..5).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- enable  input  1  active-high advance; when low, all state holds.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  block can accept an input.
- bin_in  input  WIDTH  unsigned binary operand.
- out_valid  output  1  bcd_out holds a completed result.
- out_ready  input  1  consumer accepts the result.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].

Behaviour:
- Reset (clear_n low at the rising edge of clk): state IDLE, out_valid=0, bcd_out=0, shift/scratch registers=0, bit counter=0. in_ready=1 the cycle after reset. Reset overrides enable and any in-flight conversion; a partial result is discarded.
- FSM states: IDLE, SHIFT, DONE. All transitions are qualified by enable=1; with enable=0 the state and all registers hold.
- in_ready is 1 only in IDLE; it is combinational from state.
- IDLE:
  - On in_valid & in_ready & enable: load bin_in into the binary shift register, clear the BCD scratch, load counter=WIDTH, go to SHIFT.
- SHIFT, each enabled cycle:
  - Add 3 to every scratch nibble >= 5.
  - Then shift {scratch, binary} left by 1 as one combined operation.
  - Decrement the counter.
  - When the counter reaches 0 on this edge, copy the scratch to bcd_out, set out_valid=1, go to DONE.
- Latency: out_valid rises exactly WIDTH enabled cycles after the accepting edge. Each enable=0 cycle adds one cycle.
- DONE:
  - out_valid=1 and bcd_out is stable.
  - On out_ready & enable: out_valid=0, go to IDLE. No new input is accepted in the same cycle.
  - Throughput is one result per WIDTH+2 cycles.
- bcd_out keeps its last value after the handshake until the next result is loaded. It never shows intermediate scratch values.
- Width rule: the scratch is 4*DIGITS bits. If 2^WIDTH-1 exceeds 10^DIGITS-1, the upper digits are silently truncated (modulo 10^DIGITS) unless the optional feature below is enabled.
- in_valid while not in IDLE is ignored. bin_in is sampled only on the accepting edge.

Optional Feature:
- Macro: BIN2BCD_OVF_EN.
- With the macro defined:
  - Adds output port ovf (1 bit).
  - ovf is registered with bcd_out and set when a carry is shifted out of the top digit during conversion, i.e. the value exceeds 10^DIGITS-1.
  - ovf clears on reset and on the output handshake.
- Without the macro: no ovf port and no overflow logic; truncation is silent.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the BCD adjust constants (threshold 5, correction 3);
  - the nibble width constant 4.
- One sub-module is natural: bcd_adjust_digit, a combinational block giving 4-bit in -> 4-bit out, adding 3 if the input is >= 5. It is instantiated DIGITS times by generate.

Test Plan:
- Basic conversion: reset, then drive bin_in=6'd45 with in_valid=1 and out_ready=1. Expect bcd_out=8'h45 with out_valid high exactly 6 cycles after acceptance.
- Boundary values (one conversion each): bin_in=0 -> 8'h00; bin_in=9 -> 8'h09; bin_in=10 -> 8'h10; bin_in=63 -> 8'h63.
- Backpressure: hold out_ready=0 for 5 cycles after 6'd37. Expect out_valid and bcd_out=8'h37 stable, in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
- Enable stall: drop enable for 3 cycles mid-SHIFT on 6'd58. Expect result 8'h58 after 9 cycles instead of 6.
- Reset mid-operation: assert clear_n=0 during the third SHIFT cycle. Expect IDLE, out_valid=0, bcd_out=0 next cycle; a following conversion of 6'd21 gives 8'h21.
- Sweep fed by the 6-bit counter: convert 0..63 in sequence. Expect every result to match the reference decimal; with BIN2BCD_OVF_EN and DIGITS=1, bin_in=12 gives ovf=1, bcd_out=4'h2.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, double-dabble adjust constants and nibble width.
package bin2bcd_seq_pkg;

    localparam int NIBBLE_W = 4;

    // A nibble >= 5 would exceed 9 after doubling, so it is pre-corrected by 3.
    localparam logic [NIBBLE_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [NIBBLE_W-1:0] ADJ_CORR   = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready bundle between a binary producer/BCD consumer (master) and
// the converter (slave). The ovf signal exists only when BIN2BCD_OVF_EN
// is defined.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
);
    import bin2bcd_seq_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             bin_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [NIBBLE_W*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_OVF_EN
    logic                         ovf;

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, ovf
    );

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, ovf
    );
`else
    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out
    );

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out
    );
`endif

endinterface

// File: rtl/bin2bcd_seq_adjust_digit.sv
// Single-digit double-dabble correction: adds 3 to a BCD nibble >= 5 so
// that the following left shift carries correctly into the next digit.
module bcd_adjust_digit
    import bin2bcd_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit_in,
    output logic [NIBBLE_W-1:0] digit_out
);

    // Conditional +3 correction; purely combinational.
    assign digit_out = (digit_in >= ADJ_THRESH) ? digit_in + ADJ_CORR : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per enabled
// clock, valid/ready handshake on input and output.
// Optional feature: define BIN2BCD_OVF_EN to add the ovf output, which
// flags results whose value exceeds 10^DIGITS-1 (upper digits truncated).
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               enable,
    bin2bcd_seq_if.slave       bus
);

    localparam int BCD_W  = NIBBLE_W * DIGITS;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int COMB_W = BCD_W + WIDTH;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [COMB_W-1:0]  comb_pre;
    logic [COMB_W-1:0]  comb_shifted;

    logic accept;
    logic shift_en;
    logic last_shift;
    logic release_out;

    // Per-digit add-3 correction on the current scratch.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_adjust_digit u_adj (
            .digit_in  (scratch_q[d*NIBBLE_W +: NIBBLE_W]),
            .digit_out (adjusted [d*NIBBLE_W +: NIBBLE_W])
        );
    end

    // {scratch, binary} moves left as a single vector; the top scratch bit
    // falls off the end, which is what truncates values beyond DIGITS.
    assign comb_pre     = {adjusted, bin_q};
    assign comb_shifted = comb_pre << 1;

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.bcd_out   = bcd_q;

    // State register with synchronous clear.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle action strobes; nothing moves without enable.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d     = state_q;
        accept      = 1'b0;
        shift_en    = 1'b0;
        last_shift  = 1'b0;
        release_out = 1'b0;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        accept  = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_en = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        last_shift = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        release_out = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef BIN2BCD_OVF_EN
    logic ovf_acc_q;
    logic ovf_q;
    logic carry_out;

    assign carry_out = comb_pre[COMB_W-1];
    assign bus.ovf   = ovf_q;

    // Sticky record of any carry lost off the top digit, published with bcd_out.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            ovf_acc_q <= 1'b0;
        end else if (shift_en) begin
            ovf_acc_q <= ovf_acc_q | carry_out;
            if (last_shift) begin
                ovf_q <= ovf_acc_q | carry_out;
            end
        end else if (release_out) begin
            ovf_q <= 1'b0;
        end
    end
`endif

    // Datapath: load operand, run one double-dabble step per enabled cycle,
    // and publish the scratch only on the final step.
    always_ff @(posedge clk) begin
        // NOTE: the whole datapath, including the result register, is cleared
        // so a discarded partial conversion can never leak onto bcd_out.
        if (!clear_n) begin
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else if (accept) begin
            bin_q     <= bus.bin_in;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(WIDTH);
        end else if (shift_en) begin
            bin_q     <= comb_shifted[WIDTH-1:0];
            scratch_q <= comb_shifted[COMB_W-1:WIDTH];
            cnt_q     <= cnt_q - CNT_W'(1);
            if (last_shift) begin
                bcd_q <= comb_shifted[COMB_W-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq against a decimal-arithmetic
// reference. Define BIN2BCD_OVF_EN for both RTL and bench to check ovf.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 6;
    localparam int DIGITS = 2;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int LIMIT  = 200;

    logic clk = 1'b0;
    logic clear_n;
    logic enable;

    int n_checks = 0;
    int n_errors = 0;

    logic [BCD_W-1:0] last_bcd;

    bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .enable  (enable),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Decimal digits of v, lowest DIGITS kept, packed 4 bits per digit.
    function automatic logic [BCD_W-1:0] ref_bcd(int unsigned v);
        logic [BCD_W-1:0] r;
        int unsigned      x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full conversion: accept v, optionally drop enable for stall_len
    // cycles starting stall_at cycles after acceptance, then hold out_ready
    // low for hold cycles before completing the output handshake.
    task automatic convert(input int unsigned v, input int hold,
                           input int stall_at, input int stall_len);
        logic [BCD_W-1:0] exp;
        int               lat;
        exp = ref_bcd(v);

        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        check("out_valid_idle", bus.out_valid, 0);
        check("bcd_hold_idle", bus.bcd_out, last_bcd);
        bus.in_valid  = 1'b1;
        bus.bin_in    = WIDTH'(v);
        bus.out_ready = (hold == 0);

        @(negedge clk);
        check("in_ready_busy", bus.in_ready, 0);
        // in_valid stays high with a junk operand; both must be ignored.
        bus.bin_in = WIDTH'($urandom);

        lat = 0;
        while (!bus.out_valid && lat < LIMIT) begin
            if (lat == stall_at) enable = 1'b0;
            if (lat == stall_at + stall_len) enable = 1'b1;
            @(negedge clk);
            lat++;
            if (!bus.out_valid) check("bcd_no_intermediate", bus.bcd_out, last_bcd);
        end
        bus.in_valid = 1'b0;
        enable       = 1'b1;

        check("latency", lat, WIDTH + stall_len);
        check("bcd_result", bus.bcd_out, exp);
`ifdef BIN2BCD_OVF_EN
        check("ovf_result", bus.ovf, (v >= 10**DIGITS));
`endif
        last_bcd = exp;

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_bcd_stable", bus.bcd_out, exp);
            check("bp_in_ready", bus.in_ready, 0);
        end

        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_release", bus.out_valid, 0);
        check("in_ready_release", bus.in_ready, 1);
        check("bcd_after_release", bus.bcd_out, exp);
`ifdef BIN2BCD_OVF_EN
        check("ovf_release", bus.ovf, 0);
`endif
    endtask

    initial begin
        clear_n       = 1'b0;
        enable        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.bin_in    = '0;
        bus.out_ready = 1'b0;
        last_bcd      = '0;

        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_bcd", bus.bcd_out, 0);
`ifdef BIN2BCD_OVF_EN
        check("rst_ovf", bus.ovf, 0);
`endif

        // Basic and boundary conversions.
        convert(45, 0, -1, 0);
        convert(0,  0, -1, 0);
        convert(9,  0, -1, 0);
        convert(10, 0, -1, 0);
        convert(63, 0, -1, 0);

        // Output backpressure, then an enable stall mid-conversion.
        convert(37, 5, -1, 0);
        convert(58, 0, 2, 3);

        // Clear during the third shift cycle discards the partial result.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.bin_in   = WIDTH'(45);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        clear_n = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_bcd", bus.bcd_out, 0);
        last_bcd = '0;
        convert(21, 0, -1, 0);

        // Counter-style sweep over the whole input range.
        for (int v = 0; v < (1 << WIDTH); v++) begin
            convert(v, 0, -1, 0);
        end

        // Random operands with random backpressure and stalls.
        for (int k = 0; k < 24; k++) begin
            convert($urandom_range((1 << WIDTH) - 1, 0), $urandom_range(3, 0),
                    $urandom_range(WIDTH - 1, 0), $urandom_range(3, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
